// File: rtl/btn_sel_pkg.sv
// btn_sel_pkg: shared constants and helpers for the push-button selection block.
//   MODE_EXCL / MODE_TOGGLE : encodings of the o_mode bit
//   onehot_to_idx           : binary index of the highest set bit (0 for zero input)
//   is_onehot               : true when exactly one bit is set
package btn_sel_pkg;

    localparam logic MODE_EXCL   = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    localparam int unsigned VEC_W = 32;

    function automatic int unsigned onehot_to_idx(input logic [VEC_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [VEC_W-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (v[i]) ones = ones + 1;
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/btn_sel_ctrl_if.sv
// btn_sel_ctrl_if: button inputs and selection outputs of btn_sel_ctrl.
//   i_btn / i_mode_btn : raw, bouncing board buttons
//   o_sel, o_sel_idx, o_sel_none, o_press, o_mode : registered selection state
// Modports: master = button source / consumer, slave = btn_sel_ctrl.
interface btn_sel_ctrl_if #(
    parameter int unsigned N_BTN = 3
);
    localparam int unsigned IDX_W = $clog2(N_BTN);

    logic [N_BTN-1:0] i_btn;
    logic             i_mode_btn;
    logic [N_BTN-1:0] o_sel;
    logic [IDX_W-1:0] o_sel_idx;
    logic             o_sel_none;
    logic [N_BTN-1:0] o_press;
    logic             o_mode;

    modport master (
        output i_btn, i_mode_btn,
        input  o_sel, o_sel_idx, o_sel_none, o_press, o_mode
    );

    modport slave (
        input  i_btn, i_mode_btn,
        output o_sel, o_sel_idx, o_sel_none, o_press, o_mode
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- 2-FF synchroniser, optional debouncer,
// and rising-edge detector.
//   clock, i_reset : system clock, async active-high reset
//   i_raw          : raw asynchronous button level
//   o_stable       : accepted (debounced) level
//   o_rise         : high for one cycle after o_stable goes 0 -> 1
// Macro BTN_SEL_DEBOUNCE_EN: defined = counter debouncer of DEBOUNCE_CYC cycles,
// undefined = synchroniser output is taken as the stable level directly.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_cyc
        $error("btn_debounce: DEBOUNCE_CYC must be at least 1");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic stable;

`ifdef BTN_SEL_DEBOUNCE_EN
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles of disagreement; accept the new level on the
    // cycle the count would reach DEBOUNCE_CYC. Any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync2_q;
`endif

    // Synchroniser and previous-level tracking.
    always_comb begin
        sync1_d = i_raw;
        sync2_d = sync1_q;
        prev_d  = stable;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_stable = stable;
    assign o_rise   = stable & ~prev_q;

endmodule

// File: rtl/btn_sel_ctrl.sv
// btn_sel_ctrl: push-button selection front end.
//   clock, i_reset : system clock, async active-high reset
//   bus (slave)    : i_btn[N_BTN], i_mode_btn in; o_sel (one-hot or zero),
//                    o_sel_idx, o_sel_none, o_press, o_mode out (all registered)
// Each button press selects its channel (lowest index wins on ties); pressing
// the already-selected channel clears the selection only in toggle mode. The
// mode button inverts o_mode. Debouncing is enabled by BTN_SEL_DEBOUNCE_EN.
module btn_sel_ctrl
    import btn_sel_pkg::*;
#(
    parameter int unsigned N_BTN        = 3,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned RESET_SEL    = 1
) (
    input  logic          clock,
    input  logic          i_reset,
    btn_sel_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_BTN);
    localparam logic [N_BTN-1:0] SEL_RST = N_BTN'(RESET_SEL);
    localparam logic [IDX_W-1:0] IDX_RST = IDX_W'(onehot_to_idx(RESET_SEL));
    localparam logic [N_BTN-1:0] SEL_ONE = N_BTN'(1);

    if (N_BTN < 2 || N_BTN > 16) begin : g_bad_n
        $error("btn_sel_ctrl: N_BTN must be in 2..16");
    end
    if (!is_onehot(RESET_SEL) || onehot_to_idx(RESET_SEL) >= N_BTN) begin : g_bad_rst
        $error("btn_sel_ctrl: RESET_SEL must be one-hot below bit N_BTN");
    end

    // Channels 0..N_BTN-1 are selection buttons, channel N_BTN is the mode button.
    logic [N_BTN:0] raw;
    logic [N_BTN:0] rise;
    logic [N_BTN:0] stable_unused;

    assign raw = {bus.i_mode_btn, bus.i_btn};

    for (genvar g = 0; g <= N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_deb (
            .clock    (clock),
            .i_reset  (i_reset),
            .i_raw    (raw[g]),
            .o_stable (stable_unused[g]),
            .o_rise   (rise[g])
        );
    end

    logic [N_BTN-1:0] sel_q,   sel_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             none_q,  none_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic             mode_q,  mode_d;

    logic             hit;
    logic [IDX_W-1:0] win;

    // Priority select on the old mode; mode toggles independently.
    always_comb begin
        sel_d   = sel_q;
        mode_d  = mode_q;
        press_d = rise[N_BTN-1:0];
        hit     = 1'b0;
        win     = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                hit = 1'b1;
                win = IDX_W'(i);
            end
        end
        if (hit) begin
            if (!sel_q[win]) begin
                sel_d = SEL_ONE << win;
            end else if (mode_q == MODE_TOGGLE) begin
                sel_d = '0;
            end
        end
        if (rise[N_BTN]) begin
            mode_d = ~mode_q;
        end
        idx_d  = IDX_W'(onehot_to_idx(VEC_W'(sel_d)));
        none_d = (sel_d == '0);
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sel_q   <= SEL_RST;
            idx_q   <= IDX_RST;
            none_q  <= 1'b0;
            press_q <= '0;
            mode_q  <= MODE_EXCL;
        end else begin
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            none_q  <= none_d;
            press_q <= press_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.o_sel      = sel_q;
    assign bus.o_sel_idx  = idx_q;
    assign bus.o_sel_none = none_q;
    assign bus.o_press    = press_q;
    assign bus.o_mode     = mode_q;

endmodule

// File: tb/tb_btn_sel_ctrl.sv
// tb_btn_sel_ctrl: directed bench for btn_sel_ctrl with N_BTN=3,
// DEBOUNCE_CYC=4, RESET_SEL=001. Latency follows BTN_SEL_DEBOUNCE_EN.
module tb_btn_sel_ctrl;

    localparam int unsigned N   = 3;
    localparam int unsigned DEB = 4;
`ifdef BTN_SEL_DEBOUNCE_EN
    localparam int unsigned LAT        = 3 + DEB;
    localparam int unsigned EXP_PULSES = 1;
`else
    localparam int unsigned LAT        = 3;
    localparam int unsigned EXP_PULSES = 2;
`endif

    logic clock;
    logic i_reset;

    btn_sel_ctrl_if #(.N_BTN(N)) bus ();

    btn_sel_ctrl #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (DEB),
        .RESET_SEL    (1)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] btn;
        logic       mode_btn;
        logic [2:0] press;
        logic [2:0] sel;
        logic [1:0] idx;
        logic       none;
        logic       mode;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] press, input logic [2:0] sel,
                           input logic [1:0] idx, input logic none, input logic mode);
        chk({tag, ".press"}, 32'(bus.o_press),    32'(press));
        chk({tag, ".sel"},   32'(bus.o_sel),      32'(sel));
        chk({tag, ".idx"},   32'(bus.o_sel_idx),  32'(idx));
        chk({tag, ".none"},  32'(bus.o_sel_none), 32'(none));
        chk({tag, ".mode"},  32'(bus.o_mode),     32'(mode));
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int         pulses;
        int         last;
        logic       bad;
        logic [2:0] prev_sel;

        tbl[0]  = '{3'b010, 1'b0, 3'b010, 3'b010, 2'd1, 1'b0, 1'b0};
        tbl[1]  = '{3'b101, 1'b0, 3'b101, 3'b001, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{3'b001, 1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{3'b000, 1'b1, 3'b000, 3'b001, 2'd0, 1'b0, 1'b1};
        tbl[4]  = '{3'b001, 1'b0, 3'b001, 3'b000, 2'd0, 1'b1, 1'b1};
        tbl[5]  = '{3'b001, 1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 1'b1};
        tbl[6]  = '{3'b100, 1'b0, 3'b100, 3'b100, 2'd2, 1'b0, 1'b1};
        tbl[7]  = '{3'b100, 1'b1, 3'b100, 3'b000, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{3'b100, 1'b0, 3'b100, 3'b100, 2'd2, 1'b0, 1'b0};
        tbl[9]  = '{3'b110, 1'b0, 3'b110, 3'b010, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{3'b010, 1'b1, 3'b010, 3'b010, 2'd1, 1'b0, 1'b1};
        tbl[11] = '{3'b011, 1'b0, 3'b011, 3'b001, 2'd0, 1'b0, 1'b1};
        tbl[12] = '{3'b001, 1'b0, 3'b001, 3'b000, 2'd0, 1'b1, 1'b1};
        tbl[13] = '{3'b000, 1'b1, 3'b000, 3'b000, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{3'b001, 1'b0, 3'b001, 3'b001, 2'd0, 1'b0, 1'b0};
        tbl[15] = '{3'b111, 1'b0, 3'b111, 3'b001, 2'd0, 1'b0, 1'b0};

        // Power-on reset, observed before any clock edge.
        bus.i_btn      = '0;
        bus.i_mode_btn = 1'b0;
        i_reset        = 1'b0;
        #1 i_reset = 1'b1;
        #1;
        chk_all("por", 3'b000, 3'b001, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        i_reset = 1'b0;
        tick();

        // Bouncing press on btn[2]: high 3, low 1, high 10 cycles.
        pulses = 0;
        last   = 0;
        bad    = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bus.i_btn[2] = (c <= 3) || (c >= 5 && c <= 14);
            tick();
            if (bus.o_press[2]) begin
                pulses++;
                last = c;
            end
            if (bus.o_press[1:0] != 2'b00) bad = 1'b1;
        end
        chk("bounce.pulses", 32'(pulses), 32'(EXP_PULSES));
        chk("bounce.edge", 32'(last), 32'(4 + LAT));
        chk("bounce.others", 32'(bad), 32'(0));
        chk("bounce.sel", 32'(bus.o_sel), 32'(3'b100));
        chk("bounce.idx", 32'(bus.o_sel_idx), 32'(2));

        // Asynchronous reset in the middle of a cycle.
        #2 i_reset = 1'b1;
        #1;
        chk_all("async_rst", 3'b000, 3'b001, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        i_reset = 1'b0;
        tick();

        // Table of single presses applied from the reset state.
        prev_sel = 3'b001;
        for (int v = 0; v < 16; v++) begin
            bus.i_btn      = tbl[v].btn;
            bus.i_mode_btn = tbl[v].mode_btn;
            repeat (LAT - 1) tick();
            chk($sformatf("v%0d.pre_press", v), 32'(bus.o_press), 32'(0));
            chk($sformatf("v%0d.pre_sel", v),   32'(bus.o_sel),   32'(prev_sel));
            tick();
            chk_all($sformatf("v%0d", v), tbl[v].press, tbl[v].sel, tbl[v].idx,
                    tbl[v].none, tbl[v].mode);
            tick();
            chk($sformatf("v%0d.one_cycle", v), 32'(bus.o_press), 32'(0));
            bus.i_btn      = '0;
            bus.i_mode_btn = 1'b0;
            bad = 1'b0;
            repeat (LAT + 3) begin
                tick();
                if (bus.o_press != 3'b000) bad = 1'b1;
            end
            chk($sformatf("v%0d.release", v), 32'(bad), 32'(0));
            chk($sformatf("v%0d.hold_sel", v), 32'(bus.o_sel), 32'(tbl[v].sel));
            prev_sel = tbl[v].sel;
        end

        // Reset during a held btn[2] press: press reappears after full latency.
        bus.i_btn = 3'b100;
        tick();
        tick();
        #2 i_reset = 1'b1;
        #1;
        chk("held_rst.press", 32'(bus.o_press), 32'(0));
        chk("held_rst.sel", 32'(bus.o_sel), 32'(3'b001));
        bad = 1'b0;
        repeat (2) begin
            tick();
            if (bus.o_press != 3'b000) bad = 1'b1;
        end
        chk("held_rst.in_reset", 32'(bad), 32'(0));
        i_reset = 1'b0;
        repeat (LAT - 1) tick();
        chk("held_rst.pre", 32'(bus.o_press), 32'(0));
        tick();
        chk_all("held_rst.post", 3'b100, 3'b100, 2'd2, 1'b0, 1'b0);
        tick();
        chk("held_rst.one_cycle", 32'(bus.o_press), 32'(0));
        bus.i_btn = '0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_sel_ctrl.md
# btn_sel_ctrl

Parametrised push-button front end for board-level user controls. It synchronises and debounces N_BTN selection buttons plus one mode button, then generates single-cycle rising-edge press pulses. It maintains a one-hot selection register, for example for LED colour or channel choice, and a toggled mode bit. It sits between raw board pins and the display/LED muxing logic and replaces ad-hoc per-design edge detectors.

## Interface
- N_BTN, 3, number of selection buttons; legal range 2..16.
- DEBOUNCE_CYC, 1000000, number of consecutive stable cycles required to accept a level change; must be at least 1.
- RESET_SEL, 1, one-hot selection value loaded at reset; elaboration error if not one-hot or if its bit index is at or above N_BTN.
---
- clock  in  1  single system clock; everything is rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_btn  in  N_BTN  raw selection buttons; asynchronous, bouncing.
- i_mode_btn  in  1  raw mode button; asynchronous, bouncing.
- o_sel  out  N_BTN  selection register; one-hot or all-zero.
- o_sel_idx  out  $clog2(N_BTN)  binary index of the set o_sel bit; 0 when o_sel is zero.
- o_sel_none  out  1  high when o_sel is zero.
- o_press  out  N_BTN  one-cycle registered press pulse per selection button.
- o_mode  out  1  mode bit: 0 = exclusive, 1 = toggle-off allowed.

## Operation
- Per-channel path (N_BTN+1 channels):
  - 2-FF synchroniser.
  - Debouncer: the counter runs while the synchronised level differs from the stable level and clears when they are equal. The stable level flips when the counter reaches DEBOUNCE_CYC.
  - Rising edge = stable AND NOT stable_prev.
- Selection update, applied on the edge that registers the press:
  - No press: hold o_sel.
  - One or more presses: the lowest-index pressed channel k wins.
    - If o_sel[k] is 0: o_sel becomes 1<<k.
    - If o_sel[k] is 1 and o_mode is 0: no change.
    - If o_sel[k] is 1 and o_mode is 1: o_sel becomes 0.
  - o_press reports every pressed channel, not only the winner.
- Mode: each accepted i_mode_btn rising edge inverts o_mode.
  - If a mode press and a channel press land on the same edge, the selection decision uses the old o_mode.
- Release (falling edge) events produce no output.
- Reset values:
  - o_sel = RESET_SEL; o_sel_idx = index of RESET_SEL; o_sel_none = 0.
  - o_press = 0; o_mode = 0.
  - All synchroniser, stable, stable_prev and counter state = 0.
- Reset mid-debounce discards the pending count. A button still held after reset release is detected as a new press after the full latency.
- Debounce counter width is $clog2(DEBOUNCE_CYC+1). The counter saturates and never wraps.

## Timing
- Edge 1 is the first clock edge that samples a new stable input level.
- With debounce: the stable level updates at edge 2+DEBOUNCE_CYC. o_press, o_sel, o_sel_idx, o_sel_none and o_mode update at edge 3+DEBOUNCE_CYC.
- Without debounce: the same outputs update at edge 3.
- o_press is high for exactly one cycle per accepted press, regardless of hold time.
- A glitch shorter than DEBOUNCE_CYC cycles produces no event.
- Back-to-back presses on different channels are each processed on their own edge; no press is lost.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- BTN_SEL_DEBOUNCE_EN:
  - Defined: debouncers are instantiated and latency is 3+DEBOUNCE_CYC.
  - Undefined: the synchroniser output feeds the edge detector directly, latency is 3, and DEBOUNCE_CYC is ignored. Intended for simulation and for externally debounced sources.

## Structure
- Package btn_sel_pkg holds:
  - the mode encoding constants MODE_EXCL = 0 and MODE_TOGGLE = 1;
  - a function onehot_to_idx;
  - a function is_onehot, used by the parameter check.
- Sub-module btn_debounce contains the synchroniser, debouncer and stable_prev, and outputs the stable level plus a rise pulse.
  - It is instantiated N_BTN+1 times.
  - The BTN_SEL_DEBOUNCE_EN selection lives inside it.
- The top level contains only the priority select, the mode register and the output registers.

## Test plan
All scenarios use N_BTN=3, DEBOUNCE_CYC=4, RESET_SEL=1, with the macro defined unless stated.
- Reset asserted asynchronously mid-cycle -> o_sel=001, o_sel_idx=0, o_sel_none=0, o_mode=0, o_press=000, with no clock edge required.
- i_btn[1] held high for 12 cycles -> o_press=010 for one cycle at edge 7; o_sel=010 and o_sel_idx=1 from edge 7 onward.
- i_btn[2] bounces high 3 cycles, low 1, then high 10 -> exactly one o_press[2] pulse, at edge 7 counted from the final rise; o_sel=100.
- From o_sel=010, i_btn[0] and i_btn[2] rise on the same cycle -> o_press=101 and o_sel=001.
- Mode press (o_mode goes to 1), then press the selected btn[0] -> o_sel=000, o_sel_none=1, o_sel_idx=0. A further btn[0] press gives o_sel=001. Same sequence with o_mode=0 -> o_sel unchanged.
- Reset pulsed at cycle 3 of a held i_btn[2] press, button still held -> no press during reset; o_press[2] at edge 7 after reset release. With the macro undefined, the same hold gives o_press[2] at edge 3.
